// File: rtl/instr_seq_ctrl_pkg.sv
// Shared types and encodings for the instruction sequencer and its decoder.
package instr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_ITYPE = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_to_reg;
    logic       illegal;
    logic       is_halt;
  } decode_t;

endpackage

// File: rtl/instr_seq_ctrl_decode.sv
// Combinational opcode/funct decoder producing the ALU encoding and instruction class flags.
module instr_decode
  import instr_seq_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  always_comb begin
    dec.alu_control = ALU_ITYPE;
    dec.alu_to_reg  = 1'b0;
    dec.illegal     = 1'b0;
    dec.is_halt     = 1'b0;
    if (opcode == OP_HALT) begin
      dec.is_halt     = 1'b1;
      dec.alu_control = ALU_ADD;
    end else if (opcode == OP_RTYPE) begin
      dec.alu_to_reg = 1'b1;
      case (funct)
        FN_ADD:  dec.alu_control = ALU_ADD;
        FN_SUB:  dec.alu_control = ALU_SUB;
        FN_AND:  dec.alu_control = ALU_AND;
        FN_OR:   dec.alu_control = ALU_OR;
        FN_SLL:  dec.alu_control = ALU_SLL;
        FN_SRL:  dec.alu_control = ALU_SRL;
        default: begin
          dec.alu_control = ALU_ADD;
          dec.illegal     = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the PC.
// Optional retired-instruction counter output enabled by defining INSTR_CNT_EN.
//
// state       | meaning
// S_IDLE      | stopped; waits for run=1 while not halted
// S_FETCH     | imem_req held at PC until imem_ack latches IR
// S_DECODE    | one cycle; latch ALU controls or take HALT
// S_EXECUTE   | alu_en for EXEC_CYCLES cycles (down-counter to 1)
// S_WRITEBACK | one cycle; reg_write/illegal strobe, PC += 4, sample run
module instr_seq_ctrl
  import instr_seq_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [3:0]        alu_control,
  output logic              alu_en,
  output logic              reg_write,
  output logic              alu_to_reg,
  output logic              busy,
  output logic              halted,
  output logic              illegal
`ifdef INSTR_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  localparam logic [3:0]        EXEC_LOAD = EXEC_CYCLES[3:0];
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        alu_control_q, alu_control_d;
  logic              alu_to_reg_q, alu_to_reg_d;
  logic              illegal_q, illegal_d;
  logic              halted_q, halted_d;
  decode_t           dec;
  logic              unused_ir_bits;
`ifdef INSTR_CNT_EN
  logic [31:0]       retired_q, retired_d;
`endif

  instr_decode u_decode (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .dec    (dec)
  );

  // Only opcode and funct steer the sequencer; the operand fields belong to the datapath.
  assign unused_ir_bits = ^ir_q[25:6];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      cnt_q         <= '0;
      alu_control_q <= ALU_ADD;
      alu_to_reg_q  <= 1'b0;
      illegal_q     <= 1'b0;
      halted_q      <= 1'b0;
`ifdef INSTR_CNT_EN
      retired_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      cnt_q         <= cnt_d;
      alu_control_q <= alu_control_d;
      alu_to_reg_q  <= alu_to_reg_d;
      illegal_q     <= illegal_d;
      halted_q      <= halted_d;
`ifdef INSTR_CNT_EN
      retired_q     <= retired_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    cnt_d         = cnt_q;
    alu_control_d = alu_control_q;
    alu_to_reg_d  = alu_to_reg_q;
    illegal_d     = illegal_q;
    halted_d      = halted_q;
`ifdef INSTR_CNT_EN
    retired_d     = retired_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run && !halted_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.is_halt) begin
          halted_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          alu_control_d = dec.alu_control;
          alu_to_reg_d  = dec.alu_to_reg;
          illegal_d     = dec.illegal;
          cnt_d         = EXEC_LOAD;
          state_d       = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (cnt_q == 4'd1) state_d = S_WRITEBACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_STEP;
`ifdef INSTR_CNT_EN
        retired_d = retired_q + 32'd1;
`endif
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == S_FETCH);
    imem_addr   = pc_q;
    alu_control = alu_control_q;
    alu_to_reg  = alu_to_reg_q;
    alu_en      = (state_q == S_EXECUTE);
    reg_write   = (state_q == S_WRITEBACK) && !illegal_q;
    illegal     = (state_q == S_WRITEBACK) && illegal_q;
    busy        = (state_q != S_IDLE);
    halted      = halted_q;
  end

`ifdef INSTR_CNT_EN
  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: random instruction stream against a table-driven reference model.
module tb_instr_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          EXEC   = 3;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, alu_en, reg_write, alu_to_reg, busy, halted, illegal;
  logic [31:0] imem_addr;
  logic [3:0]  alu_control;
`ifdef INSTR_CNT_EN
  logic [31:0] retired_cnt;
`endif

  instr_seq_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_control(alu_control), .alu_en(alu_en), .reg_write(reg_write), .alu_to_reg(alu_to_reg),
    .busy(busy), .halted(halted), .illegal(illegal)
`ifdef INSTR_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu;
    logic        to_reg;
    logic        wr;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          fn_map[int];
  logic [5:0]  legal_fn[6];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc;
  int          retired_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t m;
    m.pc = pc;
    if (w[31:26] == 6'd0) begin
      m.to_reg = 1'b1;
      if (fn_map.exists(int'(w[5:0]))) begin
        m.alu = 4'(fn_map[int'(w[5:0])]);
        m.wr  = 1'b1;
        m.ill = 1'b0;
      end else begin
        m.alu = 4'd0;
        m.wr  = 1'b0;
        m.ill = 1'b1;
      end
    end else begin
      m.alu    = 4'hF;
      m.to_reg = 1'b0;
      m.wr     = 1'b1;
      m.ill    = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] rword(input logic [5:0] fn);
    logic [31:0] r;
    r = $urandom();
    r[31:26] = 6'd0;
    r[5:0] = fn;
    return r;
  endfunction

  function automatic logic [31:0] iword(input logic [5:0] op);
    logic [31:0] r;
    r = $urandom();
    r[31:26] = op;
    return r;
  endfunction

  // Serve one fetch: wait for the request, hold off ack for 'delay' cycles, then deliver 'w'.
  task automatic issue(input logic [31:0] w, input int delay, input bit stray);
    int n;
    logic [31:0] a0;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req_seen", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    chk("fetch_addr", a0, model_pc);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, a0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    if (w[31:26] != 6'h3F) begin
      sb.push_back(model(w, model_pc));
      model_pc = model_pc + 32'd4;
      retired_m++;
    end
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom();
    if (stray) begin
      n = 0;
      while (!alu_en && n < 20) begin
        @(negedge clk);
        n++;
      end
      imem_ack = 1'b1;
      imem_rdata = HALT_W;
      @(negedge clk);
      imem_ack = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_retired();
`ifdef INSTR_CNT_EN
    chk("retired_cnt", retired_cnt, 32'(retired_m));
`endif
  endtask

  // Monitor: every writeback-cycle strobe pops one expected record.
  initial begin
    int en_cnt;
    exp_t e;
    en_cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy) en_cnt = 0;
      if (alu_en) en_cnt++;
      if (reg_write || illegal) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_alu_control", 32'(alu_control), 32'(e.alu));
          chk("wb_alu_to_reg", 32'(alu_to_reg), 32'(e.to_reg));
          chk("wb_reg_write", 32'(reg_write), 32'(e.wr));
          chk("wb_illegal", 32'(illegal), 32'(e.ill));
          chk("wb_pc", imem_addr, e.pc);
          chk("exec_cycles", 32'(en_cnt), 32'(EXEC));
        end
        en_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic [5:0] f;
    logic [31:0] seq[6];
    fn_map[6'b100000] = 4'b0000;
    fn_map[6'b100010] = 4'b0001;
    fn_map[6'b100100] = 4'b0010;
    fn_map[6'b100101] = 4'b0100;
    fn_map[6'b000000] = 4'b1001;
    fn_map[6'b000010] = 4'b1010;
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000, 6'b000010};

    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_alu_to_reg", 32'(alu_to_reg), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_pc", imem_addr, RST_PC);
    rst_n = 1'b1;
    model_pc = RST_PC;
    retired_m = 0;
    @(negedge clk);
    chk("idle_no_run", 32'(busy), 32'd0);
    run = 1'b1;

    // ADD, then the directed op sequence ending in an I-type; PC wraps through zero here.
    issue(32'h0022_1820, 0, 1'b0);
    seq = '{rword(6'b100010), rword(6'b100100), rword(6'b100101),
            rword(6'b000000), rword(6'b000010), iword(6'b001000)};
    foreach (seq[i]) issue(seq[i], 0, 1'b0);
    issue(rword(6'b111000), 0, 1'b0);
    issue(rword(6'b100000), 0, 1'b0);
    drain();
    chk_retired();

    issue(rword(6'b100101), 5, 1'b1);

    repeat (40) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        f = legal_fn[$urandom_range(0, 5)];
        issue(rword(f), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else if (kind == 2) begin
        issue(iword(6'($urandom_range(1, 62))), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        do f = 6'($urandom()); while (fn_map.exists(int'(f)));
        issue(rword(f), $urandom_range(0, 3), 1'b0);
      end
    end
    drain();
    chk_retired();

    // run dropped mid-instruction: finish it, then park in IDLE.
    issue(rword(6'b100100), 0, 1'b0);
    run = 1'b0;
    drain();
    repeat (4) begin
      @(negedge clk);
      chk("runlow_idle", 32'(busy), 32'd0);
      chk("runlow_no_req", 32'(imem_req), 32'd0);
    end
    run = 1'b1;

    issue(HALT_W, 0, 1'b0);
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_idle", 32'(busy), 32'd0);
      chk("halt_no_req", 32'(imem_req), 32'd0);
      chk("halt_pc", imem_addr, model_pc);
    end
    chk_retired();
    rst_n = 1'b0;
    @(negedge clk);
    chk("halt_rst_clear", 32'(halted), 32'd0);
    chk("halt_rst_pc", imem_addr, RST_PC);
    rst_n = 1'b1;
    model_pc = RST_PC;
    retired_m = 0;

    // Reset while executing abandons the instruction.
    issue(rword(6'b100010), 0, 1'b0);
    kind = 0;
    while (!alu_en && kind < 20) begin
      @(negedge clk);
      kind++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("exrst_busy", 32'(busy), 32'd0);
    chk("exrst_alu_en", 32'(alu_en), 32'd0);
    chk("exrst_alu_control", 32'(alu_control), 32'd0);
    chk("exrst_alu_to_reg", 32'(alu_to_reg), 32'd0);
    chk("exrst_pc", imem_addr, RST_PC);
    sb.delete();
    rst_n = 1'b1;
    model_pc = RST_PC;
    retired_m = 0;

    repeat (6) issue(iword(6'($urandom_range(1, 62))), 0, 1'b0);
    drain();
    chk_retired();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the single-issue datapath. It fetches a 32-bit instruction over a req/ack handshake and decodes opcode/funct into the datapath's ALU encoding. It then sequences EXECUTE and WRITEBACK, pulsing the ALU enable and register-file write strobe. It owns the PC and sits between instruction memory and the ALU/register file.

Parameters:
ADDR_W, 32, PC / imem address width
RESET_PC, 0, PC value after reset
EXEC_CYCLES, 1, cycles spent in EXECUTE (1..15)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  level; high = sequence instructions, low = stop after current instruction
imem_req  out  1  fetch request, held until accepted
imem_addr  out  ADDR_W  fetch address (= PC)
imem_ack  in  1  fetch accepted; imem_rdata valid same cycle
imem_rdata  in  32  instruction word
alu_control  out  4  ALU op, valid DECODE+1 through WRITEBACK
alu_en  out  1  high every EXECUTE cycle
reg_write  out  1  one-cycle register-file write strobe in WRITEBACK
alu_to_reg  out  1  1 = ALU result written back (R-type), 0 = I-type path
busy  out  1  state != IDLE
halted  out  1  sticky; set by HALT, cleared by reset
illegal  out  1  one-cycle pulse in WRITEBACK for an unknown R-type funct

Behaviour:
- Reset (rst_n=0 at a clock edge, any state): state=IDLE; PC=RESET_PC; IR=0; alu_control=4'b0000; all 1-bit outputs 0. An in-flight fetch is abandoned and a late imem_ack is ignored.
- IDLE: if run=1 and halted=0, go to FETCH next cycle; otherwise stay.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack=1, latch imem_rdata into IR and go to DECODE. imem_ack outside FETCH is ignored.
- DECODE (1 cycle), opcode=IR[31:26], funct=IR[5:0]:
  - opcode 6'b111111 = HALT: set halted, go to IDLE, PC unchanged.
  - opcode 0, R-type: ADD 100000->0000, SUB 100010->0001, AND 100100->0010, OR 100101->0100, SLL 000000->1001, SRL 000010->1010. Any other funct marks the instruction illegal and sets alu_control=0000.
  - Any other opcode, I-type: alu_control=1111, alu_to_reg=0.
  - R-type sets alu_to_reg=1.
  - Non-HALT goes to EXECUTE with the cycle counter loaded.
- EXECUTE: alu_en=1 for exactly EXEC_CYCLES cycles (4-bit down-counter), then WRITEBACK.
- WRITEBACK (1 cycle):
  - reg_write=1 unless illegal; illegal=1 if illegal.
  - PC <= PC+4, wrapping modulo 2^ADDR_W.
  - Next state is FETCH if run=1, else IDLE.
- Per-instruction latency with zero-wait imem: 1 (FETCH, ack same cycle) + 1 + EXEC_CYCLES + 1.
- run falling mid-instruction: the current instruction completes through WRITEBACK, then IDLE. run is sampled only in IDLE and WRITEBACK.
- imem_ack never arriving: remain in FETCH indefinitely with imem_req held.

Optional Feature:
INSTR_CNT_EN
- Defined: adds output retired_cnt [31:0]. It increments in every WRITEBACK cycle, including illegal instructions, and wraps at 2^32. It resets to 0. HALT does not count.
- Undefined: the port and counter are absent.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK)
  - opcode constants (OP_RTYPE, OP_HALT)
  - funct constants
  - ALU encoding constants (ALU_ADD .. ALU_SRL, ALU_ITYPE=4'b1111)
- One sub-module, instr_decode: combinational opcode/funct -> {alu_control, alu_to_reg, illegal, is_halt}. The FSM, PC and counters stay in the top.

Test Plan:
1. Reset then run=1, imem_ack immediate, IR=0x00221820 (ADD) -> alu_control=0000, alu_to_reg=1, reg_write pulse 4 cycles after FETCH entry, PC 0->4.
2. Sequence SUB, AND, OR, SLL(funct 000000), SRL, I-type opcode 001000 -> alu_control 0001, 0010, 0100, 1001, 1010, 1111 in order; alu_to_reg=0 only for I-type.
3. R-type funct 6'b111000 -> illegal pulse in WRITEBACK, reg_write=0, PC still +4, next fetch proceeds.
4. imem_ack delayed 5 cycles -> imem_req held 6 cycles with stable imem_addr. A stray imem_ack in EXECUTE has no effect.
5. HALT word 0xFC000000 -> halted=1, IDLE, no reg_write, PC unchanged. run held high stays idle until rst_n=0, after which PC=RESET_PC.
6. rst_n=0 during EXECUTE -> next cycle IDLE with all outputs 0. With PC=0xFFFFFFFC and ADDR_W=32, WRITEBACK wraps PC to 0. With INSTR_CNT_EN, retired_cnt counts 6 after six instructions.
